// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: power-up and recovery sequencer for the iCE40 SB_PLL40.
// Pulses the PLL RESETB pin, waits for LOCK, requires LOCK to stay high for a
// stable window, then releases the core's system reset. Retries on timeout and
// reports failure once the retry budget is spent.
// Runs on the board reference clock so it keeps working while the PLL is unstable.
// Optional build macro PLL_LOCK_LOSS_COUNTER_EN adds a saturating 8-bit
// lockLossCount output counting lock drops seen while running.
// fsm_state exposes the current state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABILIZE,
// 3 RUN, 4 FAIL.
// relockReq is a single-cycle pulse; it is acted on in whichever cycle it is
// high, with no ready/acknowledge handshake.
module pll_lock_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 12000,
   parameter int STABLE_CYCLES = 1200,
   parameter int MAX_RETRIES   = 7
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               isLockedRaw,
   input  logic                               relockReq,
   output logic                               pllResetB,
   output logic                               sysReset,
   output logic                               ready,
   output logic                               failed,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retryCount,
`ifdef PLL_LOCK_LOSS_COUNTER_EN
   output logic [7:0]                         lockLossCount,
`endif
   output logic [2:0]                         fsm_state
);

   localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CW     = $clog2(MAX_P) + 1;
   localparam int RW     = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RST_LOAD    = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LOAD   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABILIZE = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   logic [2:0]    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [RW-1:0] retry, retry_nx;
   logic          sync1, lk;

   // Two-flop synchronizer for the asynchronous PLL LOCK pin.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         lk    <= 1'b0;
      end else begin
         sync1 <= isLockedRaw;
         lk    <= sync1;
      end
   end

   // Next-state, shared counter and retry bookkeeping; relockReq overrides everything.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      retry_nx = retry;
      if (relockReq) begin
         state_nx = S_PLL_RST;
         cnt_nx   = RST_LOAD;
         retry_nx = '0;
      end else begin
         case (state)
            S_PLL_RST: begin
               if (cnt == '0) begin
                  state_nx = S_WAIT_LOCK;
                  cnt_nx   = WAIT_LOAD;
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (lk) begin
                  state_nx = S_STABILIZE;
                  cnt_nx   = STABLE_LOAD;
               end else if (cnt == '0) begin
                  if (retry < RETRY_MAX) begin
                     retry_nx = retry + 1'b1;
                     state_nx = S_PLL_RST;
                     cnt_nx   = RST_LOAD;
                  end else begin
                     state_nx = S_FAIL;
                  end
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_STABILIZE: begin
               // A glitch restarts the lock wait but is not counted as a retry.
               if (!lk) begin
                  state_nx = S_WAIT_LOCK;
                  cnt_nx   = WAIT_LOAD;
               end else if (cnt == '0) begin
                  state_nx = S_RUN;
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            S_RUN: begin
               if (!lk) begin
                  state_nx = S_PLL_RST;
                  cnt_nx   = RST_LOAD;
               end
            end
            S_FAIL: begin
               state_nx = S_FAIL;
            end
            default: begin
               state_nx = S_PLL_RST;
               cnt_nx   = RST_LOAD;
            end
         endcase
      end
      if ((state_nx == S_RUN) && (state != S_RUN)) begin
         retry_nx = '0;
      end
   end

   // State registers plus outputs registered from the next state so they
   // change on the same edge as the transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_PLL_RST;
         cnt        <= RST_LOAD;
         retry      <= '0;
         pllResetB  <= 1'b0;
         sysReset   <= 1'b1;
         ready      <= 1'b0;
         failed     <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         retry      <= retry_nx;
         pllResetB  <= !((state_nx == S_PLL_RST) || (state_nx == S_FAIL));
         sysReset   <= (state_nx != S_RUN);
         ready      <= (state_nx == S_RUN);
         failed     <= (state_nx == S_FAIL);
      end
   end

   assign retryCount = retry;
   assign fsm_state  = state;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
   // Saturating count of lock drops while running; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         lockLossCount <= 8'd0;
      end else if ((state == S_RUN) && !lk && !relockReq && (lockLossCount != 8'hFF)) begin
         lockLossCount <= lockLossCount + 8'd1;
      end
   end
`else
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: a cycle model pushes the expected output
// vector after every clock edge and a monitor pops and compares it on the
// following falling edge; directed scenarios add latency/width checks.
module tb_pll_lock_sequencer;

   localparam int RC = 16;
   localparam int LT = 200;
   localparam int SC = 120;
   localparam int MR = 7;
   localparam int RW = $clog2(MR + 1);

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABILIZE = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   logic          clk;
   logic          reset;
   logic          is_locked_raw;
   logic          relock_req;
   logic          pll_reset_b;
   logic          sys_reset;
   logic          ready;
   logic          failed;
   logic [RW-1:0] retry_count;
   logic [7:0]    lock_loss_count;
   logic [2:0]    fsm_state;

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_q[$];
   logic [17:0] act_vec;

   pll_lock_sequencer #(
      .RESET_CYCLES (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .MAX_RETRIES  (MR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .isLockedRaw  (is_locked_raw),
      .relockReq    (relock_req),
      .pllResetB    (pll_reset_b),
      .sysReset     (sys_reset),
      .ready        (ready),
      .failed       (failed),
      .retryCount   (retry_count),
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      .lockLossCount(lock_loss_count),
`endif
      .fsm_state    (fsm_state)
   );

`ifndef PLL_LOCK_LOSS_COUNTER_EN
   assign lock_loss_count = 8'd0;
`endif

   assign act_vec = {pll_reset_b, sys_reset, ready, failed, retry_count, fsm_state, lock_loss_count};

   // Clock and power-on stimulus defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: phase timers count up from zero, separate lock pipeline.
   logic [2:0]    m_st = S_PLL_RST;
   int            m_el = 0;
   logic [RW-1:0] m_retry = '0;
   int            m_loss = 0;
   logic          m_s1 = 1'b0;
   logic          m_lk = 1'b0;

   task automatic model_step();
      logic lk_now;
      logic pb;
      if (reset) begin
         m_st = S_PLL_RST; m_el = 0; m_retry = '0; m_loss = 0; m_s1 = 1'b0; m_lk = 1'b0;
      end else begin
         lk_now = m_lk;
         if (relock_req) begin
            m_st = S_PLL_RST; m_el = 0; m_retry = '0;
         end else begin
            case (m_st)
               S_PLL_RST:
                  if (m_el == RC - 1) begin m_st = S_WAIT_LOCK; m_el = 0; end
                  else m_el++;
               S_WAIT_LOCK:
                  if (lk_now) begin m_st = S_STABILIZE; m_el = 0; end
                  else if (m_el == LT - 1) begin
                     if (int'(m_retry) < MR) begin m_retry++; m_st = S_PLL_RST; m_el = 0; end
                     else m_st = S_FAIL;
                  end else m_el++;
               S_STABILIZE:
                  if (!lk_now) begin m_st = S_WAIT_LOCK; m_el = 0; end
                  else if (m_el == SC - 1) begin m_st = S_RUN; m_retry = '0; end
                  else m_el++;
               S_RUN:
                  if (!lk_now) begin
                     m_st = S_PLL_RST; m_el = 0;
                     if (m_loss < 255) m_loss++;
                  end
               default: ;
            endcase
         end
         m_lk = m_s1;
         m_s1 = is_locked_raw;
      end
      pb = !((m_st == S_PLL_RST) || (m_st == S_FAIL));
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      exp_q.push_back({pb, m_st != S_RUN, m_st == S_RUN, m_st == S_FAIL, m_retry, m_st, 8'(m_loss)});
`else
      exp_q.push_back({pb, m_st != S_RUN, m_st == S_RUN, m_st == S_FAIL, m_retry, m_st, 8'd0});
`endif
   endtask

   always @(posedge clk) model_step();

   // Scoreboard: compare every cycle's outputs away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) check("cycle", 32'(act_vec), 32'(exp_q.pop_front()));
   end

   task automatic wait_state(input logic [2:0] target, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((fsm_state !== target) && (n < budget));
   endtask

   task automatic pulse_relock();
      relock_req = 1'b1;
      @(negedge clk);
      relock_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pllb"},  32'(pll_reset_b), 32'd0);
      check({tag, "_sysr"},  32'(sys_reset),   32'd1);
      check({tag, "_ready"}, 32'(ready),       32'd0);
      check({tag, "_fail"},  32'(failed),      32'd0);
      check({tag, "_retry"}, 32'(retry_count), 32'd0);
      check({tag, "_state"}, 32'(fsm_state),   32'(S_PLL_RST));
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      check({tag, "_llc"},   32'(lock_loss_count), 32'd0);
`endif
   endtask

   initial begin
      int n;
      int len;
      logic [7:0] loss_before;
      reset = 1'b1;
      is_locked_raw = 1'b0;
      relock_req = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;

      // Power-up: RESETB low for RC cycles, lock after 100 cycles, stable window.
      wait_state(S_WAIT_LOCK, 100, n);
      check("rstb_width", 32'(n), 32'(RC));
      check("rstb_high", 32'(pll_reset_b), 32'd1);
      repeat (100) @(negedge clk);
      is_locked_raw = 1'b1;
      wait_state(S_STABILIZE, 20, n);
      check("stab_lat", 32'(n), 32'd3);
      wait_state(S_RUN, SC + 20, n);
      check("run_lat", 32'(n), 32'(SC));
      check("run_ready", 32'(ready), 32'd1);
      check("run_sysr", 32'(sys_reset), 32'd0);
      check("run_retry", 32'(retry_count), 32'd0);

      // Lock drop in RUN, one timeout, then a short glitch during STABILIZE.
      is_locked_raw = 1'b0;
      wait_state(S_PLL_RST, 20, n);
      check("drop_lat", 32'(n), 32'd3);
      check("drop_sysr", 32'(sys_reset), 32'd1);
      check("drop_ready", 32'(ready), 32'd0);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (pll_reset_b !== 1'b0) break;
         n++;
      end
      check("drop_pulse", 32'(n), 32'(RC));
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      check("llc_one", 32'(lock_loss_count), 32'd1);
`endif
      wait_state(S_PLL_RST, LT + 50, n);
      check("timeout_len", 32'(n), 32'(LT));
      check("retry_one", 32'(retry_count), 32'd1);
      wait_state(S_WAIT_LOCK, 50, n);
      repeat (50) @(negedge clk);
      is_locked_raw = 1'b1;
      wait_state(S_STABILIZE, 20, n);
      check("stab2_lat", 32'(n), 32'd3);
      repeat (60) @(negedge clk);
      is_locked_raw = 1'b0;
      wait_state(S_WAIT_LOCK, 20, n);
      check("glitch_lat", 32'(n), 32'd3);
      is_locked_raw = 1'b1;
      check("glitch_retry", 32'(retry_count), 32'd1);
      wait_state(S_STABILIZE, 20, n);
      check("relock_lat", 32'(n), 32'd3);
      wait_state(S_RUN, SC + 20, n);
      check("full_window", 32'(n), 32'(SC));
      check("retry_cleared", 32'(retry_count), 32'd0);

      // Lock never returns: retries exhaust into FAIL.
      is_locked_raw = 1'b0;
      wait_state(S_FAIL, 4000, n);
      check("fail_time", 32'(n), 32'(3 + (MR + 1) * (RC + LT)));
      check("fail_flag", 32'(failed), 32'd1);
      check("fail_retry", 32'(retry_count), 32'(MR));
      check("fail_pllb", 32'(pll_reset_b), 32'd0);
      check("fail_sysr", 32'(sys_reset), 32'd1);
      repeat (LT + 100) @(negedge clk);
      check("fail_sticky", 32'(fsm_state), 32'(S_FAIL));

      // relockReq out of FAIL, then a normal bring-up.
      is_locked_raw = 1'b1;
      pulse_relock();
      check("rlk_state", 32'(fsm_state), 32'(S_PLL_RST));
      check("rlk_fail", 32'(failed), 32'd0);
      check("rlk_retry", 32'(retry_count), 32'd0);
      wait_state(S_RUN, 1000, n);
      check("rlk_run", 32'(n), 32'(RC + 1 + SC));

      // relockReq on the same edge that first sees the lock drop.
      loss_before = lock_loss_count;
      is_locked_raw = 1'b0;
      repeat (2) @(negedge clk);
      pulse_relock();
      check("both_state", 32'(fsm_state), 32'(S_PLL_RST));
      check("both_llc", 32'(lock_loss_count), 32'(loss_before));
      is_locked_raw = 1'b1;
      wait_state(S_RUN, 1000, n);
      check("both_run", 32'(fsm_state), 32'(S_RUN));

      // Random lock runs with occasional relock and reset pulses.
      for (int k = 0; k < 14; k++) begin
         is_locked_raw = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 260);
         for (int j = 0; j < len; j++) begin
            @(negedge clk);
            relock_req = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 999) == 0);
         end
      end
      @(negedge clk);
      relock_req = 1'b0;
      reset = 1'b0;

      // Reset asserted during STABILIZE.
      is_locked_raw = 1'b1;
      pulse_relock();
      wait_state(S_STABILIZE, 500, n);
      check("pre_rst_state", 32'(fsm_state), 32'(S_STABILIZE));
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
